// File: rtl/timer_arbiter.sv
// ============================================================================
// timer_arbiter : round-robin sharing of one millisecond delay timer
// Revision      : 1.0
// ============================================================================
`default_nettype none

module timer_arbiter #(
  parameter int NREQ = 4,
  parameter int TW   = 13
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*TW-1:0] tms_i,
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    done_o,
  output logic               busy_o,
  output logic [TW-1:0]      timer_tms_o,
  input  logic               timer_rdy_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   timer_tms_q, timer_tms_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [TW-1:0]   win_tms;

  // First requester found searching upward from the one after the last served.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NREQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_tms = tms_i[int'(win_idx)*TW +: TW];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    timer_tms_d = timer_tms_q;
    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        timer_tms_d = '0;
        if (win_found) begin
          sel_d = win_idx;
          ptr_d = win_idx;
          if (win_tms != '0) begin
            state_d     = RUN;
            gnt_d       = NREQ'(1) << win_idx;
            timer_tms_d = win_tms;
          end else begin
            // Zero delay completes immediately without touching the timer.
            state_d = STOP;
            done_d  = NREQ'(1) << win_idx;
          end
        end
      end
      RUN: begin
        if (timer_rdy_i) begin
          state_d     = STOP;
          done_d      = NREQ'(1) << sel_q;
          gnt_d       = '0;
          timer_tms_d = '0;
        end else if (!req_i[sel_q]) begin
          state_d     = STOP;
          gnt_d       = '0;
          timer_tms_d = '0;
        end
      end
      STOP: begin
        state_d     = IDLE;
        gnt_d       = '0;
        timer_tms_d = '0;
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        timer_tms_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NREQ - 1);
      sel_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      timer_tms_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      timer_tms_q <= timer_tms_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign timer_tms_o = timer_tms_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_arbiter.sv
// ============================================================================
// tb_timer_arbiter : directed self-checking bench for timer_arbiter
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_timer_arbiter;

  localparam int NREQ = 4;
  localparam int TW   = 13;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*TW-1:0] tms;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [TW-1:0]      timer_tms;
  logic               timer_rdy;

  int checks = 0;
  int errors = 0;

  timer_arbiter #(.NREQ(NREQ), .TW(TW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .tms_i       (tms),
    .gnt_o       (gnt),
    .done_o      (done),
    .busy_o      (busy),
    .timer_tms_o (timer_tms),
    .timer_rdy_i (timer_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_tms(input int idx, input int val);
    tms[idx*TW +: TW] = TW'(val);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Grant g from IDLE, complete it via rdy, drop req in the done cycle.
  task automatic serve(input string tag, input int g, input bit reraise);
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(1) << g);
    timer_rdy = 1'b1;
    tick();
    chk({tag, "_done"}, 32'(done), 32'(1) << g);
    timer_rdy = 1'b0;
    req[g]    = 1'b0;
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    if (reraise) req[g] = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    req       = '0;
    tms       = '0;
    timer_rdy = 1'b0;
    tick();
    tick();
    chk("rst_gnt",  32'(gnt),       32'd0);
    chk("rst_done", 32'(done),      32'd0);
    chk("rst_busy", 32'(busy),      32'd0);
    chk("rst_tms",  32'(timer_tms), 32'd0);
    rst = 1'b1;
    tick();

    // Single request
    req = 4'b0001;
    set_tms(0, 1);
    tick();
    chk("single_gnt",  32'(gnt),       32'h1);
    chk("single_tms",  32'(timer_tms), 32'd1);
    chk("single_busy", 32'(busy),      32'd1);
    chk("single_done", 32'(done),      32'd0);
    repeat (3) tick();
    chk("single_hold", 32'(gnt),       32'h1);
    timer_rdy = 1'b1;
    tick();
    chk("single_done1", 32'(done),      32'h1);
    chk("single_stop",  32'(timer_tms), 32'd0);
    chk("single_gnt0",  32'(gnt),       32'd0);
    chk("single_sbusy", 32'(busy),      32'd1);
    timer_rdy = 1'b0;
    req       = '0;
    tick();
    chk("single_done0", 32'(done), 32'd0);
    chk("single_idle",  32'(busy), 32'd0);

    // Round-robin 0,2,0,2
    do_reset();
    tick();
    set_tms(2, 1);
    req = 4'b0101;
    serve("rr_a", 0, 1'b1);
    serve("rr_b", 2, 1'b1);
    serve("rr_c", 0, 1'b1);
    serve("rr_d", 2, 1'b0);
    req = '0;

    // Late req[1] slots in between 0 and 2
    do_reset();
    tick();
    set_tms(1, 1);
    req = 4'b0101;
    tick();
    chk("rr1_gnt0", 32'(gnt), 32'h1);
    req[1]    = 1'b1;
    timer_rdy = 1'b1;
    tick();
    timer_rdy = 1'b0;
    req[0]    = 1'b0;
    tick();
    serve("rr1_b", 1, 1'b0);
    serve("rr1_c", 2, 1'b0);

    // Zero delay
    do_reset();
    tick();
    set_tms(1, 0);
    req = 4'b0010;
    tick();
    chk("zero_done", 32'(done),      32'h2);
    chk("zero_gnt",  32'(gnt),       32'd0);
    chk("zero_tms",  32'(timer_tms), 32'd0);
    chk("zero_busy", 32'(busy),      32'd1);
    req = '0;
    tick();
    chk("zero_done0", 32'(done), 32'd0);
    set_tms(0, 3);
    set_tms(1, 3);
    req = 4'b0011;
    tick();
    chk("zero_ptr", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("zero_abort_done", 32'(done), 32'd0);
    tick();

    // Abort
    do_reset();
    tick();
    set_tms(3, 5);
    set_tms(0, 2);
    req = 4'b1000;
    tick();
    chk("abort_gnt", 32'(gnt),       32'h8);
    chk("abort_tms", 32'(timer_tms), 32'd5);
    set_tms(3, 7);
    req[0] = 1'b1;
    repeat (5) tick();
    chk("abort_tms_hold", 32'(timer_tms), 32'd5);
    chk("abort_gnt_hold", 32'(gnt),       32'h8);
    req[3] = 1'b0;
    tick();
    chk("abort_gnt0", 32'(gnt),       32'd0);
    chk("abort_done", 32'(done),      32'd0);
    chk("abort_stop", 32'(timer_tms), 32'd0);
    chk("abort_busy", 32'(busy),      32'd1);
    tick();
    chk("abort_idle", 32'(gnt), 32'd0);
    tick();
    chk("abort_next_gnt", 32'(gnt),       32'h1);
    chk("abort_next_tms", 32'(timer_tms), 32'd2);

    // Simultaneous rdy and abort: completion wins
    timer_rdy = 1'b1;
    req[0]    = 1'b0;
    tick();
    chk("sim_done", 32'(done), 32'h1);
    timer_rdy = 1'b0;
    tick();
    chk("sim_done_once", 32'(done), 32'd0);

    // Reset mid-RUN
    set_tms(3, 4);
    req = 4'b1001;
    tick();
    chk("mid_gnt", 32'(gnt), 32'h8);
    rst = 1'b0;
    tick();
    chk("mid_rst_gnt",  32'(gnt),       32'd0);
    chk("mid_rst_done", 32'(done),      32'd0);
    chk("mid_rst_busy", 32'(busy),      32'd0);
    chk("mid_rst_tms",  32'(timer_tms), 32'd0);
    rst = 1'b1;
    tick();
    chk("mid_regrant", 32'(gnt),       32'h1);
    chk("mid_regtms",  32'(timer_tms), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
